// File: rtl/imm_extend_buffer.sv
// Immediate-extension stage feeding the execute operand mux.
// The extended result is held in a 2-entry skid buffer with registered valid/ready on both sides.
module imm_extend_buffer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic [OUT_W-1:0] ext;
  logic             accept;
  logic             drain;

  // Mode 11 drops the top two bits of the sign-extended value; OUT_W >= IN_W + 2 is assumed.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    logic [OUT_W-1:0] sx;
    sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend = sx;
      2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   extend = {sx[OUT_W-3:0], 2'b00};
      default: extend = sx;
    endcase
  endfunction

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  assign ext    = extend(in_imm, in_mode);

  // Occupancy FSM; in_ready is registered as "next state is not TWO".
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_tag   <= {TAG_W{1'b0}};
      skid_data <= {OUT_W{1'b0}};
      skid_tag  <= {TAG_W{1'b0}};
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_data  <= ext;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
            state     <= ONE;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_data <= ext;
            skid_tag  <= in_tag;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (drain && !accept) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= EMPTY;
          end else if (accept && drain) begin
            out_data <= ext;
            out_tag  <= in_tag;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        TWO: begin
          if (drain) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
            in_ready <= 1'b1;
            state    <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
